// File: rtl/sdram_seq.sv
// sdram_seq - SDRAM command sequencer for the GR8RAM CPLD.
//
// This block takes single-byte read and write requests from the slot-bus
// register file. It turns each one into an ACT followed by a RD or WR with
// auto-precharge on a 16-bit SDRAM. It also runs the power-up init sequence
// and the periodic auto-refresh. SCKE is held low whenever the sequencer is
// idle.
//
// Ports:
//   C25M            system clock; every state change is on its rising edge
//   nRST            asynchronous active-low reset
//   req/we/addr/wdata  request side. req is a level held until ack.
//                   addr = {bank[1:0], row[11:0], col[8:0], lane}
//   ack             one-cycle pulse when a request is accepted
//   rdata/rvalid    read byte, plus a one-cycle pulse when it is updated
//   busy            high whenever the sequencer is not in IDLE
//   init_done       high once the init sequence has completed
//   SCKE..DQMH, SBA, SA, SDout, SDOE  registered SDRAM pins
//   SDin            data from the selected byte lane
module sdram_seq #(
    parameter int INIT_WAIT  = 4096,
    parameter int REF_PERIOD = 64,
    parameter int INIT_AREFS = 8
) (
    input  logic        C25M,
    input  logic        nRST,
    input  logic        req,
    input  logic        we,
    input  logic [23:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        rvalid,
    output logic        busy,
    output logic        init_done,
    output logic        SCKE,
    output logic        nSCS,
    output logic        nRAS,
    output logic        nCAS,
    output logic        nSWE,
    output logic        DQML,
    output logic        DQMH,
    output logic [1:0]  SBA,
    output logic [12:0] SA,
    output logic [7:0]  SDout,
    output logic        SDOE,
    input  logic [7:0]  SDin
);
    localparam logic [4:0] S_RESET_WAIT = 5'd0;
    localparam logic [4:0] S_WAKE       = 5'd1;
    localparam logic [4:0] S_PREA       = 5'd2;
    localparam logic [4:0] S_PREA_NOP   = 5'd3;
    localparam logic [4:0] S_AREF_I     = 5'd4;
    localparam logic [4:0] S_AREF_I_NOP = 5'd5;
    localparam logic [4:0] S_LMR        = 5'd6;
    localparam logic [4:0] S_LMR_NOP    = 5'd7;
    localparam logic [4:0] S_IDLE       = 5'd8;
    localparam logic [4:0] S_WAKE_R     = 5'd9;
    localparam logic [4:0] S_AREF_R     = 5'd10;
    localparam logic [4:0] S_REF_NOP    = 5'd11;
    localparam logic [4:0] S_WAKE_A     = 5'd12;
    localparam logic [4:0] S_ACT        = 5'd13;
    localparam logic [4:0] S_RCD        = 5'd14;
    localparam logic [4:0] S_RW         = 5'd15;
    localparam logic [4:0] S_CL1        = 5'd16;
    localparam logic [4:0] S_CL2        = 5'd17;

    // {nSCS, nRAS, nCAS, nSWE}
    localparam logic [3:0] CMD_NOP  = 4'b1111;
    localparam logic [3:0] CMD_PREA = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;

    localparam logic [15:0] WAIT_LAST = 16'(INIT_WAIT - 1);
    localparam logic [15:0] REF_LAST  = 16'(REF_PERIOD - 1);
    localparam logic [7:0]  AREF_LAST = 8'(INIT_AREFS - 1);
    localparam logic [15:0] NOP_LAST  = 16'd2;   // three NOP cycles: 0,1,2

    logic [4:0]  state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [7:0]  aref_cnt_reg, aref_cnt_next;
    logic [15:0] ref_cnt_reg;
    logic        ref_pend_reg;
    logic        init_done_reg, ack_reg, rvalid_reg;
    logic [7:0]  rdata_reg;
    logic        we_reg;
    logic [23:0] addr_reg;
    logic [7:0]  wdata_reg;
    logic        accept;

    logic        cke_reg, cke_next;
    logic [3:0]  cmd_reg, cmd_next;
    logic [1:0]  dqm_reg, dqm_next;        // {DQMH, DQML}
    logic [1:0]  sba_reg, sba_next;
    logic [12:0] sa_reg, sa_next;
    logic        sdoe_reg, sdoe_next;
    logic [7:0]  sdout_reg, sdout_next;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        aref_cnt_next = aref_cnt_reg;
        accept        = 1'b0;
        case (state_reg)
            S_RESET_WAIT: begin
                if (cnt_reg == WAIT_LAST) begin
                    state_next = S_WAKE;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_WAKE:     state_next = S_PREA;
            S_PREA: begin
                state_next = S_PREA_NOP;
                cnt_next   = 16'd0;
            end
            S_PREA_NOP: begin
                if (cnt_reg == NOP_LAST) begin
                    state_next    = S_AREF_I;
                    aref_cnt_next = 8'd0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_AREF_I: begin
                state_next = S_AREF_I_NOP;
                cnt_next   = 16'd0;
            end
            S_AREF_I_NOP: begin
                if (cnt_reg == NOP_LAST) begin
                    if (aref_cnt_reg == AREF_LAST) begin
                        state_next = S_LMR;
                    end else begin
                        state_next    = S_AREF_I;
                        aref_cnt_next = aref_cnt_reg + 8'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_LMR: begin
                state_next = S_LMR_NOP;
                cnt_next   = 16'd0;
            end
            S_LMR_NOP: begin
                if (cnt_reg == NOP_LAST) state_next = S_IDLE;
                else                     cnt_next   = cnt_reg + 16'd1;
            end
            S_IDLE: begin
                // Refresh has priority; a waiting request stays pending.
                if (ref_pend_reg) begin
                    state_next = S_WAKE_R;
                end else if (req) begin
                    state_next = S_WAKE_A;
                    accept     = 1'b1;
                end
            end
            S_WAKE_R:   state_next = S_AREF_R;
            S_AREF_R: begin
                state_next = S_REF_NOP;
                cnt_next   = 16'd0;
            end
            S_REF_NOP: begin
                if (cnt_reg == NOP_LAST) state_next = S_IDLE;
                else                     cnt_next   = cnt_reg + 16'd1;
            end
            S_WAKE_A:   state_next = S_ACT;
            S_ACT:      state_next = S_RCD;
            S_RCD:      state_next = S_RW;
            S_RW:       state_next = S_CL1;
            S_CL1:      state_next = S_CL2;
            S_CL2:      state_next = S_IDLE;
            default:    state_next = S_RESET_WAIT;
        endcase
    end

    // The pins are decoded from the next state and then registered, so each
    // command appears on the pins during the cycle spent in its state.
    always_comb begin
        cke_next   = 1'b1;
        cmd_next   = CMD_NOP;
        dqm_next   = 2'b11;
        sba_next   = 2'b00;
        sa_next    = 13'd0;
        sdoe_next  = 1'b0;
        sdout_next = 8'd0;
        case (state_next)
            S_RESET_WAIT, S_IDLE: cke_next = 1'b0;
            S_PREA: begin
                cmd_next    = CMD_PREA;
                sa_next[10] = 1'b1;
            end
            S_AREF_I, S_AREF_R: cmd_next = CMD_AREF;
            S_LMR: begin
                // Single-write mode, CL2, sequential burst, burst length 1.
                cmd_next = CMD_LMR;
                sa_next  = 13'h0220;
            end
            S_ACT: begin
                cmd_next = CMD_ACT;
                sba_next = addr_reg[23:22];
                sa_next  = {1'b0, addr_reg[21:10]};
            end
            S_RW: begin
                // SA10 = 1 selects auto-precharge, so every access closes its row.
                cmd_next = we_reg ? CMD_WR : CMD_RD;
                sba_next = addr_reg[23:22];
                sa_next  = {2'b00, 1'b1, 1'b0, addr_reg[9:1]};
                dqm_next = {~addr_reg[0], addr_reg[0]};
                if (we_reg) begin
                    sdoe_next  = 1'b1;
                    sdout_next = wdata_reg;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge C25M or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= S_RESET_WAIT;
            cnt_reg       <= 16'd0;
            aref_cnt_reg  <= 8'd0;
            ref_cnt_reg   <= 16'd0;
            ref_pend_reg  <= 1'b0;
            init_done_reg <= 1'b0;
            ack_reg       <= 1'b0;
            rvalid_reg    <= 1'b0;
            rdata_reg     <= 8'd0;
            we_reg        <= 1'b0;
            addr_reg      <= 24'd0;
            wdata_reg     <= 8'd0;
            cke_reg       <= 1'b0;
            cmd_reg       <= CMD_NOP;
            dqm_reg       <= 2'b11;
            sba_reg       <= 2'b00;
            sa_reg        <= 13'd0;
            sdoe_reg      <= 1'b0;
            sdout_reg     <= 8'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            aref_cnt_reg <= aref_cnt_next;
            ack_reg      <= accept;
            cke_reg      <= cke_next;
            cmd_reg      <= cmd_next;
            dqm_reg      <= dqm_next;
            sba_reg      <= sba_next;
            sa_reg       <= sa_next;
            sdoe_reg     <= sdoe_next;
            sdout_reg    <= sdout_next;

            if (accept) begin
                we_reg    <= we;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end

            if (state_next == S_IDLE) init_done_reg <= 1'b1;

            // CL2: read data is on SDin at the end of the second NOP after RD.
            rvalid_reg <= (state_reg == S_CL2) && !we_reg;
            if (state_reg == S_CL2 && !we_reg) rdata_reg <= SDin;

            // The refresh timer runs only after init. The pending flag saturates.
            // A new expiry takes priority over the clear made by AREF.
            if (init_done_reg) begin
                if (ref_cnt_reg == REF_LAST) begin
                    ref_cnt_reg  <= 16'd0;
                    ref_pend_reg <= 1'b1;
                end else begin
                    ref_cnt_reg <= ref_cnt_reg + 16'd1;
                    if (state_reg == S_AREF_R) ref_pend_reg <= 1'b0;
                end
            end
        end
    end

    assign ack       = ack_reg;
    assign rdata     = rdata_reg;
    assign rvalid    = rvalid_reg;
    assign busy      = (state_reg != S_IDLE);
    assign init_done = init_done_reg;
    assign SCKE      = cke_reg;
    assign {nSCS, nRAS, nCAS, nSWE} = cmd_reg;
    assign {DQMH, DQML} = dqm_reg;
    assign SBA       = sba_reg;
    assign SA        = sa_reg;
    assign SDOE      = sdoe_reg;
    assign SDout     = sdout_reg;

endmodule

// File: tb/tb_sdram_seq.sv
// tb_sdram_seq - self-checking bench for sdram_seq.
// The bench checks the init sequence, directed and random accesses, a
// collision between a request and a refresh, the overall refresh rate, and a
// reset asserted in the middle of a read. Expected values come from the
// address field split and the cycle counts of the sequencer's contract.
module tb_sdram_seq;
    localparam int P_INIT_WAIT  = 16;
    localparam int P_REF_PERIOD = 40;
    localparam int P_INIT_AREFS = 2;

    logic        C25M = 1'b0;
    logic        nRST = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [23:0] addr = 24'd0;
    logic [7:0]  wdata = 8'd0, SDin = 8'd0;
    logic        ack, rvalid, busy, init_done;
    logic [7:0]  rdata, SDout;
    logic        SCKE, nSCS, nRAS, nCAS, nSWE, DQML, DQMH, SDOE;
    logic [1:0]  SBA;
    logic [12:0] SA;

    sdram_seq #(
        .INIT_WAIT (P_INIT_WAIT),
        .REF_PERIOD(P_REF_PERIOD),
        .INIT_AREFS(P_INIT_AREFS)
    ) dut (
        .C25M(C25M), .nRST(nRST), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .rvalid(rvalid), .busy(busy), .init_done(init_done),
        .SCKE(SCKE), .nSCS(nSCS), .nRAS(nRAS), .nCAS(nCAS), .nSWE(nSWE),
        .DQML(DQML), .DQMH(DQMH), .SBA(SBA), .SA(SA), .SDout(SDout), .SDOE(SDOE),
        .SDin(SDin)
    );

    always #5 C25M = ~C25M;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;          // number of rising edges so far
    int init_at  = 0;          // cycle in which init_done was first seen
    int post_aref_cnt = 0;     // AREF commands seen with init_done high
    int last_aref_cyc = -1;
    logic [7:0] model_rdata = 8'd0;

    always @(posedge C25M) cyc <= cyc + 1;

    // Monitor for refresh commands, sampled just after each edge.
    always begin
        @(posedge C25M);
        #1;
        if (nRST && init_done && {nSCS, nRAS, nCAS, nSWE} == 4'b0001) begin
            post_aref_cnt = post_aref_cnt + 1;
            last_aref_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [3:0] cmd_bits();
        return {nSCS, nRAS, nCAS, nSWE};
    endfunction

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_scke"}, SCKE, 0);
        check({pfx, "_ctl"}, {nSCS, nRAS, nCAS, nSWE, DQML, DQMH}, 6'h3F);
        check({pfx, "_sa"}, SA, 0);
        check({pfx, "_sba"}, SBA, 0);
        check({pfx, "_sd"}, {SDOE, SDout}, 0);
        check({pfx, "_flags"}, {ack, rvalid, init_done, busy}, 4'b0001);
        check({pfx, "_rdata"}, rdata, 0);
    endtask

    // Releases reset at the current negedge and follows the init sequence.
    // A request is held high throughout and must not be served before
    // init_done.
    task automatic run_init();
        int k, low_cnt, prea_k, aref_n, first_aref_k, lmr_k, done_k;
        logic seen_high, bad;
        logic [12:0] lmr_sa;
        logic [1:0]  lmr_sba;
        logic [3:0]  c;
        req = 1'b1; we = 1'b0; addr = 24'($urandom); nRST = 1'b1;
        k = 0; low_cnt = 0; prea_k = -1; aref_n = 0; first_aref_k = -1;
        lmr_k = -1; done_k = -1; seen_high = 1'b0; bad = 1'b0;
        lmr_sa = 13'd0; lmr_sba = 2'd0;
        while (done_k < 0 && k < 200) begin
            if (SCKE) seen_high = 1'b1;
            else if (!seen_high) low_cnt++;
            c = cmd_bits();
            if (c == 4'b0010 && SA[10] && prea_k < 0) prea_k = k;
            if (c == 4'b0001) begin
                aref_n++;
                if (first_aref_k < 0) first_aref_k = k;
            end
            if (c == 4'b0000) begin
                lmr_k = k; lmr_sa = SA; lmr_sba = SBA;
            end
            if (c == 4'b0011 || c == 4'b0101 || c == 4'b0100 || ack || rvalid) bad = 1'b1;
            if (init_done) done_k = k;
            else begin
                @(negedge C25M);
                k++;
            end
        end
        req = 1'b0;
        init_at = cyc;
        $display("init: done at cycle %0d, %0d AREF, LMR at %0d", done_k, aref_n, lmr_k);
        check("init_cke_low", low_cnt, P_INIT_WAIT);
        check("init_prea", prea_k, P_INIT_WAIT + 1);
        check("init_aref_n", aref_n, P_INIT_AREFS);
        check("init_aref_first", first_aref_k, P_INIT_WAIT + 5);
        check("init_lmr", lmr_k, P_INIT_WAIT + 5 + 4 * P_INIT_AREFS);
        check("init_lmr_sa", lmr_sa, 13'h0220);
        check("init_lmr_sba", lmr_sba, 0);
        check("init_done_cyc", done_k, P_INIT_WAIT + 1 + 4 + 4 * P_INIT_AREFS + 4);
        check("init_no_access", bad, 0);
    endtask

    // Runs one access starting at the current negedge. rd is the byte
    // presented on SDin during the second NOP after RD.
    task automatic do_access(input logic w, input logic [23:0] a, input logic [7:0] d,
                             input logic [7:0] rd, output int ack_at);
        int waited;
        we = w; addr = a; wdata = d; req = 1'b1;
        waited = 0; ack_at = -1;
        while (ack_at < 0 && waited < 40) begin
            @(negedge C25M);
            waited++;
            if (ack) ack_at = cyc;
        end
        req = 1'b0;
        if (ack_at < 0) begin
            check("ack_timeout", 0, 1);
            return;
        end
        // Scramble the inputs: the sequencer must work from the latched copy.
        we = 1'($urandom); addr = 24'($urandom); wdata = 8'($urandom);
        check("wake_a", {SCKE, nSCS}, 2'b11);
        @(negedge C25M);
        check("act_cmd", cmd_bits(), 4'b0011);
        check("act_sba", SBA, a[23:22]);
        check("act_sa", SA, {1'b0, a[21:10]});
        @(negedge C25M);
        check("rcd_nop", {nSCS, ack}, 2'b10);
        @(negedge C25M);
        check("rw_cmd", cmd_bits(), w ? 4'b0100 : 4'b0101);
        check("rw_sba", SBA, a[23:22]);
        check("rw_sa", SA, {2'b00, 1'b1, 1'b0, a[9:1]});
        check("rw_dqm", {DQML, DQMH}, {a[0], ~a[0]});
        check("rw_sdoe", SDOE, w);
        if (w) check("rw_sdout", SDout, d);
        SDin = ~rd;
        @(negedge C25M);
        check("cl1", {nSCS, SDOE, DQML, DQMH}, 4'b1011);
        @(negedge C25M);
        check("cl2", {nSCS, rvalid}, 2'b10);
        SDin = rd;
        @(negedge C25M);
        SDin = 8'($urandom);
        if (!w) model_rdata = rd;
        check("end_rvalid", rvalid, !w);
        check("end_rdata", rdata, model_rdata);
        check("end_busy", busy, 0);
        check("end_cycle", cyc, ack_at + 6);
        $display("access: we=%0d addr=%06h wdata=%02h ack@%0d rdata=%02h", w, a, d, ack_at, rdata);
    endtask

    initial begin
        int ack_at, gap, waited;
        logic early_aref;
        repeat (2) @(negedge C25M);
        check_reset_vals("rst");
        run_init();

        // No refresh until REF_PERIOD cycles after init_done; then a read
        // request arrives in the same cycle as the pending flag.
        early_aref = 1'b0;
        while (cyc < init_at + P_REF_PERIOD) begin
            @(negedge C25M);
            if (post_aref_cnt != 0) early_aref = 1'b1;
        end
        check("no_early_aref", early_aref, 0);
        do_access(1'b0, 24'h000002, 8'h00, 8'h3C, ack_at);
        check("coll_aref_cyc", last_aref_cyc, init_at + P_REF_PERIOD + 2);
        check("coll_ack_cyc", ack_at, init_at + P_REF_PERIOD + 7);
        check("coll_rdata", rdata, 8'h3C);

        do_access(1'b1, 24'h123457, 8'hA5, 8'h00, ack_at);
        do_access(1'b0, 24'hFFFFFF, 8'h00, 8'h96, ack_at);
        do_access(1'b1, 24'hFFFFFF, 8'h5A, 8'h00, ack_at);

        for (int i = 0; i < 24; i++) begin
            gap = int'($urandom_range(0, 4));
            repeat (gap) @(negedge C25M);
            do_access(1'($urandom), 24'($urandom), 8'($urandom), 8'($urandom), ack_at);
        end

        // Let the most recent expiry be served, then compare the number of
        // AREFs with the number of elapsed refresh periods.
        waited = 0;
        while (((cyc - init_at) % P_REF_PERIOD) != 12 && waited < P_REF_PERIOD + 2) begin
            @(negedge C25M);
            waited++;
        end
        check("ref_count", post_aref_cnt, (cyc - init_at) / P_REF_PERIOD);

        // Reset asserted during the ACT cycle of a read.
        we = 1'b0; addr = 24'h3ABCDE; req = 1'b1;
        ack_at = -1; waited = 0;
        while (ack_at < 0 && waited < 40) begin
            @(negedge C25M);
            waited++;
            if (ack) ack_at = cyc;
        end
        req = 1'b0;
        check("mid_ack_seen", ack_at >= 0, 1);
        @(negedge C25M);
        check("mid_act", cmd_bits(), 4'b0011);
        nRST = 1'b0;
        #1;
        model_rdata = 8'd0;
        check_reset_vals("mid");
        @(negedge C25M);
        run_init();
        do_access(1'b0, 24'h000001, 8'h00, 8'hC3, ack_at);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
